// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART TX/RX framing logic: frame state encoding,
// data width, line-level constants, parity-mode constants and the parity
// helper function.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Parity modes (value XORed into the data parity)
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity bit to transmit for a byte: even mode gives the XOR of the data,
  // odd mode its complement.
  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data,
                                      input logic                   mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter shared by the UART TX and RX paths. Counts
// 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
//
// Ports:
//   clk      system clock (rising edge)
//   rst      asynchronous active-high reset
//   clr      synchronous clear; forces the count to 0 on the next edge
//   bit_end  high while the count equals CLKS_PER_BIT-1 (bit boundary)
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter; restarts at 0 on clear or after the last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign bit_end = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit framing controller sitting in front of an 8-bit PISO shift
// register. Captures a byte on tx_start, loads it into the PISO, then shifts
// it out LSB first between a start bit, an optional parity bit and one or two
// stop bits.
//
// Ports:
//   clk        system clock (rising edge)
//   rst        asynchronous active-high reset
//   tx_start   send request, sampled only while idle
//   tx_data    byte to send
//   tx_busy    high while a frame is in progress
//   tx_done    one-cycle pulse in the idle cycle that ends a frame
//   tx_datain  registered byte presented to the PISO
//   load_data  one-cycle PISO load strobe
//   shift      one-cycle PISO shift-right strobe
//   databit    PISO LSB (current data bit)
//   txd        serial output, idles high
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_start,
  input  logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic [UART_DATA_W-1:0] tx_datain,
  output logic                   load_data,
  output logic                   shift,
  input  logic                   databit,
  output logic                   txd
);

  localparam logic       PAR_ON    = (PARITY_EN != 0);
  localparam logic       PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_W - 1);

  tx_state_e state_r;
  tx_state_e state_s;

  logic [2:0]             bit_cnt_r;
  logic [2:0]             bit_cnt_s;
  logic                   stop_cnt_r;
  logic                   stop_cnt_s;
  logic                   par_r;
  logic                   par_s;
  logic                   txd_s;
  logic                   tx_busy_s;
  logic                   tx_done_s;
  logic                   load_data_s;
  logic                   shift_s;
  logic [UART_DATA_W-1:0] tx_datain_s;
  logic                   bit_end_s;
  logic                   baud_clr_s;

  // The baud counter is held at 0 while idle and restarted on every state
  // change so each state begins a fresh bit period.
  assign baud_clr_s = (state_r == IDLE) || (state_s != state_r);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (baud_clr_s),
    .bit_end(bit_end_s)
  );

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (tx_start) state_s = START;
        else          state_s = IDLE;
      end
      START: begin
        if (bit_end_s) state_s = DATA;
        else           state_s = START;
      end
      DATA: begin
        if (bit_end_s && (bit_cnt_r == LAST_BIT)) begin
          if (PAR_ON) state_s = PARITY;
          else        state_s = STOP;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) state_s = STOP;
        else           state_s = PARITY;
      end
      STOP: begin
        if (bit_end_s && (stop_cnt_r == STOP_LAST)) state_s = IDLE;
        else                                        state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath counters. txd is
  // updated one edge ahead so it changes exactly on the bit boundary.
  always_comb begin
    txd_s       = txd;
    tx_busy_s   = tx_busy;
    tx_done_s   = 1'b0;
    load_data_s = 1'b0;
    shift_s     = 1'b0;
    tx_datain_s = tx_datain;
    par_s       = par_r;
    bit_cnt_s   = bit_cnt_r;
    stop_cnt_s  = stop_cnt_r;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          txd_s       = START_BIT;
          tx_busy_s   = 1'b1;
          load_data_s = 1'b1;
          tx_datain_s = tx_data;
          par_s       = parity_bit(tx_data, PAR_MODE);
          bit_cnt_s   = 3'd0;
          stop_cnt_s  = 1'b0;
        end else begin
          txd_s     = LINE_IDLE;
          tx_busy_s = 1'b0;
        end
      end
      START: begin
        tx_busy_s = 1'b1;
        if (bit_end_s) begin
          // PISO was loaded during the start bit, so databit is bit 0 here.
          txd_s     = databit;
          shift_s   = 1'b1;
          bit_cnt_s = 3'd0;
        end else begin
          txd_s = START_BIT;
        end
      end
      DATA: begin
        tx_busy_s = 1'b1;
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            txd_s      = PAR_ON ? par_r : LINE_IDLE;
            bit_cnt_s  = 3'd0;
            stop_cnt_s = 1'b0;
          end else begin
            // Shift at the start of each bit so the next bit is ready well
            // before the following boundary.
            txd_s     = databit;
            shift_s   = 1'b1;
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          txd_s = txd;
        end
      end
      PARITY: begin
        tx_busy_s = 1'b1;
        if (bit_end_s) begin
          txd_s      = LINE_IDLE;
          stop_cnt_s = 1'b0;
        end else begin
          txd_s = par_r;
        end
      end
      STOP: begin
        txd_s = LINE_IDLE;
        if (bit_end_s) begin
          if (stop_cnt_r == STOP_LAST) begin
            tx_busy_s  = 1'b0;
            tx_done_s  = 1'b1;
            stop_cnt_s = 1'b0;
          end else begin
            tx_busy_s  = 1'b1;
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          tx_busy_s = 1'b1;
        end
      end
      default: begin
        txd_s     = LINE_IDLE;
        tx_busy_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset drives the line high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd        <= LINE_IDLE;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      load_data  <= 1'b0;
      shift      <= 1'b0;
      tx_datain  <= '0;
      par_r      <= 1'b0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
    end else begin
      txd        <= txd_s;
      tx_busy    <= tx_busy_s;
      tx_done    <= tx_done_s;
      load_data  <= load_data_s;
      shift      <= shift_s;
      tx_datain  <= tx_datain_s;
      par_r      <= par_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Four uart_tx_ctrl instances with different framing parameters share one
// stimulus stream. A frame-level model decides which requests each instance
// accepts and queues the expected frame; one monitor per instance checks the
// serial waveform and the PISO strobes cycle by cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;

  logic [3:0] txd_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [3:0] load_w;
  logic [3:0] shift_w;
  logic [3:0] databit_w;
  logic [7:0] datain_w [4];
  logic [7:0] piso [4];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    int         e;
  } frame_t;

  frame_t exp_q [4][$];
  int     next_free [4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance parameters: 0 even/1 stop, 1 odd/1 stop, 2 no parity/2 stop,
  // 3 odd/2 stop at the minimum bit period.
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx_datain(datain_w[0]),
    .load_data(load_w[0]), .shift(shift_w[0]), .databit(databit_w[0]), .txd(txd_w[0]));
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx_datain(datain_w[1]),
    .load_data(load_w[1]), .shift(shift_w[1]), .databit(databit_w[1]), .txd(txd_w[1]));
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx_datain(datain_w[2]),
    .load_data(load_w[2]), .shift(shift_w[2]), .databit(databit_w[2]), .txd(txd_w[2]));
  uart_tx_ctrl #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[3]), .tx_done(done_w[3]), .tx_datain(datain_w[3]),
    .load_data(load_w[3]), .shift(shift_w[3]), .databit(databit_w[3]), .txd(txd_w[3]));

  // Simple PISO per instance: load on load_data, shift right on shift
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (load_w[g])       piso[g] <= datain_w[g];
      else if (shift_w[g]) piso[g] <= {1'b0, piso[g][7:1]};
    end
  end

  always_comb begin
    for (int g = 0; g < 4; g++) databit_w[g] = piso[g][0];
  end

  function automatic int cpb(input int g);
    return (g == 3) ? 2 : 4;
  endfunction

  function automatic int pe(input int g);
    return (g == 2) ? 0 : 1;
  endfunction

  function automatic int odd(input int g);
    return (g == 1 || g == 3) ? 1 : 0;
  endfunction

  function automatic int sb(input int g);
    return (g >= 2) ? 2 : 1;
  endfunction

  function automatic int flen(input int g);
    return cpb(g) * (1 + 8 + pe(g) + sb(g));
  endfunction

  // Expected line level for frame slot b: start, 8 data bits LSB first,
  // optional parity, then stop bits.
  function automatic int exp_bit(input int g, input logic [7:0] d, input int b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (b == 0) return 0;
    if (b <= 8) return int'(d[b-1]);
    if (pe(g) == 1 && b == 9) begin
      if (odd(g) == 1) return ((ones % 2) == 0) ? 1 : 0;
      else             return ((ones % 2) == 1) ? 1 : 0;
    end
    return 1;
  endfunction

  task automatic chk(input string nm, input int g, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, g, cyc, act, want);
    end
  endtask

  // Drive inputs for the next rising edge and let the model decide which
  // instances accept the request.
  task automatic drive(input logic s, input logic [7:0] d);
    int     e;
    frame_t f;
    @(negedge clk);
    tx_start = s;
    tx_data  = d;
    e = cyc + 1;
    if (s && !rst) begin
      for (int g = 0; g < 4; g++) begin
        if (e >= next_free[g]) begin
          f.d = d;
          f.e = e;
          exp_q[g].push_back(f);
          next_free[g] = e + flen(g) + 1;
        end
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int budget;
    bit pend;
    budget = 400;
    pend   = 1'b1;
    while (pend && budget > 0) begin
      drive(1'b0, 8'($urandom));
      pend = 1'b0;
      for (int g = 0; g < 4; g++)
        if (exp_q[g].size() != 0 || cyc < next_free[g]) pend = 1'b1;
      budget--;
    end
    if (pend) chk({nm, "_timeout"}, 0, 1, 0);
  endtask

  task automatic mon(input int g);
    frame_t f;
    int     nsh;
    int     nld;
    bit     ab;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (load_w[g]) begin
        if (exp_q[g].size() == 0) begin
          chk("unexpected_load", g, 1, 0);
        end else begin
          f = exp_q[g].pop_front();
          chk("accept_edge", g, cyc, f.e);
          chk("tx_datain", g, int'(datain_w[g]), int'(f.d));
          nsh = 0;
          nld = 0;
          ab  = 1'b0;
          for (int k = 0; k < flen(g); k++) begin
            if (k > 0) begin
              @(posedge clk);
              #1;
              if (rst) begin
                ab = 1'b1;
                break;
              end
            end
            nsh += int'(shift_w[g]);
            nld += int'(load_w[g]);
            chk("txd_busy_done", g, int'({txd_w[g], busy_w[g], done_w[g]}),
                (exp_bit(g, f.d, k / cpb(g)) * 4) + 2);
          end
          if (!ab) begin
            @(posedge clk);
            #1;
            if (!rst) begin
              chk("frame_end", g,
                  int'({txd_w[g], busy_w[g], done_w[g], shift_w[g], load_w[g]}), 5'b10100);
              chk("shift_pulses", g, nsh, 8);
              chk("load_pulses", g, nld, 1);
            end
          end
        end
      end else begin
        chk("idle_line", g, int'({txd_w[g], busy_w[g], shift_w[g], done_w[g]}), 4'b1000);
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
      mon(3);
    join_none
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    for (int g = 0; g < 4; g++) next_free[g] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 0, int'(txd_w), 4'hF);
    chk("rst_busy", 0, int'(busy_w), 4'h0);
    chk("rst_done", 0, int'(done_w), 4'h0);
    chk("rst_load", 0, int'(load_w), 4'h0);
    chk("rst_shift", 0, int'(shift_w), 4'h0);
    for (int g = 0; g < 4; g++) chk("rst_datain", g, int'(datain_w[g]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b0, 8'h00);

    // Directed bytes, with start pulses and data churn while busy
    drive(1'b1, 8'hA5);
    for (int i = 0; i < 20; i++) drive((i % 5) == 2, 8'($urandom));
    wait_idle("a5");
    drive(1'b1, 8'h01);
    wait_idle("01");
    drive(1'b1, 8'hFF);
    wait_idle("ff");

    // tx_start held high: back-to-back frames, 3C then C3
    for (int i = 0; i < 150; i++) drive(1'b1, (i < 2) ? 8'h3C : 8'hC3);
    for (int i = 0; i < 100; i++) drive(1'b1, 8'($urandom));
    wait_idle("b2b");

    // Random traffic
    for (int i = 0; i < 1500; i++) drive($urandom_range(0, 7) == 0, 8'($urandom));
    wait_idle("rand");

    // Asynchronous reset during data bit 3 of the CLKS_PER_BIT=4 frames
    drive(1'b1, 8'($urandom));
    tx_start = 1'b1;
    repeat (17) @(posedge clk);
    tx_start = 1'b0;
    #2;
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_q[g].delete();
      next_free[g] = 0;
    end
    #1;
    chk("arst_txd", 0, int'(txd_w), 4'hF);
    chk("arst_busy", 0, int'(busy_w), 4'h0);
    chk("arst_strobes", 0, int'({load_w, shift_w}), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("arst_hold", 0, int'({txd_w, busy_w, load_w, shift_w}), 16'hF000);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h5A);
    wait_idle("post_rst");

    for (int g = 0; g < 4; g++) chk("pending_frames", g, exp_q[g].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
